// File: rtl/data_unpacker_pkg.sv
// Unpack-mode codes shared with the trace data packer, plus the FSM state type
// and the helper that turns a firmware mode byte into a slice length.
package data_unpacker_pkg;

   typedef enum logic [7:0] {
      MODE_N = 8'd0,
      MODE_M = 8'd1,
      MODE_1 = 8'd2
   } unpack_mode_e;

   typedef enum logic {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } unpack_state_e;

   // A length of 0 marks an unknown mode byte: such vectors are consumed and dropped.
   function automatic int mode_to_len(input logic [7:0] mode, input int n, input int m);
      int len;
      case (mode)
         MODE_N:  len = n;
         MODE_M:  len = m;
         MODE_1:  len = 1;
         default: len = 0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/data_unpacker_slice_mux.sv
// Selects the current slice out of the aligned buffer: elements ptr..ptr+count-1
// land at indices 0..count-1 and every index above the slice reads as zero.
module unpack_slice_mux
   import data_unpacker_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CW         = $clog2(N) + 1
) (
   input  logic [N-1:0][DATA_WIDTH-1:0] slice_buf,
   input  logic [CW-1:0]                ptr,
   input  logic [CW-1:0]                count,
   output logic [N-1:0][DATA_WIDTH-1:0] vector_out
);

   logic [N-1:0][DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted    = slice_buf >> (int'(ptr) * DATA_WIDTH);
      vector_out = '0;
      for (int i = 0; i < N; i++) begin
         if (i < int'(count)) begin
            vector_out[i] = shifted[i];
         end
      end
   end

endmodule

// File: rtl/data_unpacker.sv
// Trace data unpacker: accepts packed N-wide vectors and replays them as slices of
// N, M or 1 elements (oldest first), with the slice width chosen per chain by firmware.
module data_unpacker
   import data_unpacker_pkg::*;
#(
   parameter int N                  = 8,
   parameter int M                  = 2,
   parameter int DATA_WIDTH         = 32,
   parameter int MAX_CHAINS         = 4,
   parameter int PERSONAL_CONFIG_ID = 0,
   parameter logic [0:MAX_CHAINS-1][7:0] INITIAL_FIRMWARE = '0,
   localparam int CW = $clog2(N) + 1,
   localparam int IW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tracing,
   input  logic [7:0]                   configId,
   input  logic [7:0]                   configData,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
   input  logic [CW-1:0]                count_in,
   input  logic [IW-1:0]                chainId_in,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
   output logic [CW-1:0]                count_out,
   output logic                         last_out
);

   unpack_state_e state_q, state_d;

   logic [N-1:0][DATA_WIDTH-1:0] buf_q;
   logic [N-1:0][DATA_WIDTH-1:0] aligned;
   logic [CW-1:0]                ptr_q, rem_q, len_q;
   logic [CW-1:0]                cnt_in, new_len, slice_len;
   logic [0:MAX_CHAINS-1][7:0]   firmware_q;
   logic [7:0]                   byte_counter_q;
   logic                         accept, handshake, is_last;

   // Input alignment: the valid top elements are shifted down to index 0 and the
   // slice length for the producing chain is looked up so it can be latched.
   always_comb begin
      if (count_in == '0 || count_in > CW'(N)) begin
         cnt_in = CW'(N);
      end else begin
         cnt_in = count_in;
      end
      aligned = vector_in >> ((N - int'(cnt_in)) * DATA_WIDTH);
      new_len = '0;
      if (int'(chainId_in) < MAX_CHAINS) begin
         new_len = CW'(mode_to_len(firmware_q[chainId_in], N, M));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; a final slice handshake may coincide with
   // a new accept so consecutive vectors stream without a bubble.
   always_comb begin
      state_d   = state_q;
      valid_out = (state_q == DRAIN);
      slice_len = (len_q < rem_q) ? len_q : rem_q;
      is_last   = (rem_q <= len_q);
      count_out = valid_out ? slice_len : '0;
      last_out  = valid_out & is_last;
      handshake = valid_out & ready_in;
      ready_out = rst_n & tracing & ((state_q == EMPTY) | (handshake & last_out));
      accept    = valid_in & ready_out;
      if (accept) begin
         state_d = (new_len == '0) ? EMPTY : DRAIN;
      end else if (handshake && is_last) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
         ptr_q <= '0;
         rem_q <= '0;
         len_q <= '0;
      end else if (accept) begin
         buf_q <= aligned;
         ptr_q <= '0;
         rem_q <= cnt_in;
         len_q <= new_len;
      end else if (handshake && !is_last) begin
         ptr_q <= ptr_q + len_q;
         rem_q <= rem_q - len_q;
      end
   end

   // Firmware bytes stream in over the shared config bus while tracing is low;
   // any other configId rewinds the byte counter for the next write burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         firmware_q     <= INITIAL_FIRMWARE;
         byte_counter_q <= '0;
      end else if (!tracing) begin
         if (configId == 8'(PERSONAL_CONFIG_ID)) begin
            if (int'(byte_counter_q) < MAX_CHAINS) begin
               firmware_q[byte_counter_q[IW-1:0]] <= configData;
            end
            if (byte_counter_q != 8'hFF) begin
               byte_counter_q <= byte_counter_q + 8'd1;
            end
         end else begin
            byte_counter_q <= '0;
         end
      end
   end

   unpack_slice_mux #(
      .N         (N),
      .DATA_WIDTH(DATA_WIDTH),
      .CW        (CW)
   ) u_slice_mux (
      .slice_buf (buf_q),
      .ptr       (ptr_q),
      .count     (count_out),
      .vector_out(vector_out)
   );

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker (N=8, M=2, 32-bit elements): a per-cycle vector
// table followed by hand sequences for reconfiguration, drop and reset mid-drain.
module tb_data_unpacker;

   typedef logic [7:0][31:0] vec_t;

   typedef struct {
      logic       tr;
      logic       vi;
      logic       ri;
      logic [1:0] ch;
      logic [3:0] cnt;
      vec_t       vin;
      logic       ev;
      logic [3:0] ec;
      logic       el;
      logic       er;
      vec_t       evec;
   } row_t;

   logic       clk;
   logic       rst_n;
   logic       tracing;
   logic [7:0] configId;
   logic [7:0] configData;
   logic       valid_in;
   logic       ready_out;
   vec_t       vector_in;
   logic [3:0] count_in;
   logic [1:0] chainId_in;
   logic       valid_out;
   logic       ready_in;
   vec_t       vector_out;
   logic [3:0] count_out;
   logic       last_out;

   int total = 0;
   int bad   = 0;
   row_t tbl[$];

   data_unpacker #(
      .N(8), .M(2), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tracing(tracing), .configId(configId),
      .configData(configData), .valid_in(valid_in), .ready_out(ready_out),
      .vector_in(vector_in), .count_in(count_in), .chainId_in(chainId_in),
      .valid_out(valid_out), .ready_in(ready_in), .vector_out(vector_out),
      .count_out(count_out), .last_out(last_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v8(input int a0 = 0, input int a1 = 0, input int a2 = 0,
                               input int a3 = 0, input int a4 = 0, input int a5 = 0,
                               input int a6 = 0, input int a7 = 0);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
      return v;
   endfunction

   function automatic row_t mk(input logic tr, input logic vi, input logic ri,
                               input logic [1:0] ch, input logic [3:0] cnt, input vec_t vin,
                               input logic ev, input logic [3:0] ec, input logic el,
                               input logic er, input vec_t evec);
      row_t r;
      r.tr = tr; r.vi = vi; r.ri = ri; r.ch = ch; r.cnt = cnt; r.vin = vin;
      r.ev = ev; r.ec = ec; r.el = el; r.er = er; r.evec = evec;
      return r;
   endfunction

   task automatic checkOne(input string what, input int row, input logic [255:0] act,
                           input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s row %0d: got %h expected %h", what, row, act, exp);
      end
   endtask

   task automatic checkNow(input int row, input logic ev, input logic [3:0] ec,
                           input logic el, input logic er, input vec_t evec);
      checkOne("valid_out", row, 256'(valid_out), 256'(ev));
      checkOne("count_out", row, 256'(count_out), 256'(ec));
      checkOne("last_out", row, 256'(last_out), 256'(el));
      checkOne("ready_out", row, 256'(ready_out), 256'(er));
      checkOne("vector_out", row, vector_out, evec);
   endtask

   task automatic applyStimulus(input row_t r);
      @(posedge clk);
      #1;
      configId   = 8'hFF;
      tracing    = r.tr;
      valid_in   = r.vi;
      ready_in   = r.ri;
      chainId_in = r.ch;
      count_in   = r.cnt;
      vector_in  = r.vin;
   endtask

   task automatic checkOutput(input int row, input row_t r);
      @(negedge clk);
      checkNow(row, r.ev, r.ec, r.el, r.er, r.evec);
   endtask

   task automatic configure(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] bytes [4];
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         tracing    = 1'b0;
         valid_in   = 1'b0;
         configId   = 8'd0;
         configData = bytes[k];
      end
      @(posedge clk);
      #1;
      configId = 8'hFF;
   endtask

   initial begin
      vec_t z, v18, vb;
      row_t h;
      z   = '0;
      v18 = v8(1, 2, 3, 4, 5, 6, 7, 8);
      vb  = v8(0, 0, 0, 0, 0, 0, 31, 32);

      rst_n = 1'b0; tracing = 1'b1; configId = 8'hFF; configData = 8'd0;
      valid_in = 1'b0; ready_in = 1'b1; vector_in = '0; count_in = '0; chainId_in = '0;

      // firmware after the configure call below: chain0=M, chain1=1, chain2=N, chain3=drop
      tbl.push_back(mk(1, 1, 1, 0, 8, v18, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 1, 2, 0, 0, v8(1, 2)));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 1, 2, 0, 0, v8(3, 4)));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 1, 2, 0, 0, v8(5, 6)));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 1, 2, 1, 1, v8(7, 8)));
      tbl.push_back(mk(1, 1, 1, 1, 3, v8(99, 99, 99, 99, 99, 10, 20, 30), 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 1, 3, z, 1, 1, 0, 0, v8(10)));
      tbl.push_back(mk(1, 0, 1, 1, 3, z, 1, 1, 0, 0, v8(20)));
      tbl.push_back(mk(1, 1, 1, 2, 5, v8(7, 7, 7, 100, 101, 102, 103, 104), 1, 1, 1, 1, v8(30)));
      tbl.push_back(mk(1, 0, 1, 2, 5, z, 1, 5, 1, 1, v8(100, 101, 102, 103, 104)));
      tbl.push_back(mk(1, 1, 1, 0, 5, v8(0, 0, 0, 11, 12, 13, 14, 15), 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 0, 5, z, 1, 2, 0, 0, v8(11, 12)));
      tbl.push_back(mk(1, 0, 1, 0, 5, z, 1, 2, 0, 0, v8(13, 14)));
      tbl.push_back(mk(1, 0, 1, 0, 5, z, 1, 1, 1, 1, v8(15)));
      tbl.push_back(mk(1, 1, 1, 0, 8, v8(21, 22, 23, 24, 25, 26, 27, 28), 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 1, 1, 1, 2, vb, 1, 2, 0, 0, v8(21, 22)));
      tbl.push_back(mk(1, 1, 0, 1, 2, vb, 1, 2, 0, 0, v8(23, 24)));
      tbl.push_back(mk(1, 1, 0, 1, 2, vb, 1, 2, 0, 0, v8(23, 24)));
      tbl.push_back(mk(1, 1, 1, 1, 2, vb, 1, 2, 0, 0, v8(23, 24)));
      tbl.push_back(mk(1, 1, 1, 1, 2, vb, 1, 2, 0, 0, v8(25, 26)));
      tbl.push_back(mk(1, 1, 1, 1, 2, vb, 1, 2, 1, 1, v8(27, 28)));
      tbl.push_back(mk(1, 0, 1, 1, 2, z, 1, 1, 0, 0, v8(31)));
      tbl.push_back(mk(1, 0, 1, 1, 2, z, 1, 1, 1, 1, v8(32)));
      tbl.push_back(mk(1, 0, 1, 0, 0, z, 0, 0, 0, 1, z));
      tbl.push_back(mk(0, 1, 1, 0, 8, v18, 0, 0, 0, 0, z));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 1, 1, 0, 4, v8(0, 0, 0, 0, 41, 42, 43, 44), 0, 0, 0, 1, z));
      tbl.push_back(mk(0, 1, 1, 0, 8, v18, 1, 2, 0, 0, v8(41, 42)));
      tbl.push_back(mk(0, 1, 1, 0, 8, v18, 1, 2, 1, 0, v8(43, 44)));
      tbl.push_back(mk(0, 1, 1, 0, 8, v18, 0, 0, 0, 0, z));
      tbl.push_back(mk(1, 0, 1, 0, 8, z, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 1, 1, 3, 8, v18, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 3, 8, z, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 1, 1, 2, 0, v18, 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 2, 0, z, 1, 8, 1, 1, v18));
      tbl.push_back(mk(1, 1, 1, 2, 12, v8(9, 8, 7, 6, 5, 4, 3, 2), 0, 0, 0, 1, z));
      tbl.push_back(mk(1, 0, 1, 2, 12, z, 1, 8, 1, 1, v8(9, 8, 7, 6, 5, 4, 3, 2)));

      #3;
      checkNow(-1, 0, 0, 0, 0, z);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released, loading firmware {1,2,0,3}");
      configure(8'd1, 8'd2, 8'd0, 8'd3);

      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         checkOutput(k, tbl[k]);
      end

      // Reconfigure to {2,0,7,1}: chain2 now drops, chain1 is full width, chain0 single.
      $display("[TB] reconfiguring firmware {2,0,7,1}");
      configure(8'd2, 8'd0, 8'd7, 8'd1);
      h = mk(1, 1, 1, 2, 8, v18, 0, 0, 0, 1, z);
      applyStimulus(h); checkOutput(100, h);
      h = mk(1, 0, 1, 2, 8, z, 0, 0, 0, 1, z);
      applyStimulus(h); checkOutput(101, h);
      h = mk(1, 1, 1, 1, 8, v8(61, 62, 63, 64, 65, 66, 67, 68), 0, 0, 0, 1, z);
      applyStimulus(h); checkOutput(102, h);
      h = mk(1, 0, 1, 1, 8, z, 1, 8, 1, 1, v8(61, 62, 63, 64, 65, 66, 67, 68));
      applyStimulus(h); checkOutput(103, h);
      h = mk(1, 1, 1, 0, 3, v8(0, 0, 0, 0, 0, 51, 52, 53), 0, 0, 0, 1, z);
      applyStimulus(h); checkOutput(104, h);
      h = mk(1, 0, 1, 0, 3, z, 1, 1, 0, 0, v8(51));
      applyStimulus(h); checkOutput(105, h);

      // Reset pulse mid-drain, away from any clock edge.
      #1;
      rst_n = 1'b0;
      #1;
      checkNow(106, 0, 0, 0, 0, z);
      @(negedge clk);
      rst_n = 1'b1;

      // Restored firmware puts chain0 back in full-width mode.
      h = mk(1, 1, 1, 0, 8, v18, 0, 0, 0, 1, z);
      applyStimulus(h); checkOutput(107, h);
      h = mk(1, 0, 1, 0, 8, z, 1, 8, 1, 1, v18);
      applyStimulus(h); checkOutput(108, h);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
